// File: rtl/axi_err_responder.sv
// rtl/axi_err_responder.sv - AXI4 terminating subordinate answering every burst with a fixed error
package axi_pkg;
    localparam int unsigned IdW   = 4;
    localparam int unsigned AddrW = 32;
    localparam int unsigned DataW = 64;
    localparam int unsigned UserW = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [AddrW-1:0] addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [5:0]       atop;
    } aw_chan_t;

    typedef struct packed {
        logic [DataW-1:0]   data;
        logic [DataW/8-1:0] strb;
        logic               last;
        logic [UserW-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [1:0]       resp;
        logic [UserW-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [AddrW-1:0] addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
    } ar_chan_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [DataW-1:0] data;
        logic [1:0]       resp;
        logic             last;
        logic [UserW-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;
endpackage

module axi_err_responder #(
    parameter logic [1:0] Resp     = axi_pkg::RESP_DECERR,
    parameter type        data_t   = logic [axi_pkg::DataW-1:0],
    parameter data_t      RespData = data_t'(64'hCA11AB1EBADCAB1E),
    parameter type        b_chan_t = axi_pkg::b_chan_t,
    parameter type        r_chan_t = axi_pkg::r_chan_t,
    parameter type        req_t    = axi_pkg::req_t,
    parameter type        resp_t   = axi_pkg::resp_t
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  req_t  slv_req_i,
    output resp_t slv_resp_o
);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;
    b_chan_t  b_q, b_d;
    r_chan_t  r_q, r_d;
    logic [7:0] cnt_q, cnt_d;

    // Address, strobe, write data and burst attributes are deliberately ignored.
    logic unused_req;
    assign unused_req = ^slv_req_i;

    always_comb begin
        w_state_d = w_state_q;
        b_d       = b_q;
        case (w_state_q)
            W_IDLE: begin
                if (slv_req_i.aw_valid) begin
                    b_d       = '0;
                    b_d.id    = slv_req_i.aw.id;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (slv_req_i.w_valid && slv_req_i.w.last) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (slv_req_i.b_ready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        r_d       = r_q;
        cnt_d     = cnt_q;
        case (r_state_q)
            R_IDLE: begin
                if (slv_req_i.ar_valid) begin
                    r_d       = '0;
                    r_d.id    = slv_req_i.ar.id;
                    cnt_d     = slv_req_i.ar.len;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (slv_req_i.r_ready) begin
                    if (cnt_q == 8'd0) begin
                        r_state_d = R_IDLE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Handshake signals come from state only, so no input reaches an output combinationally.
    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = (w_state_q == W_IDLE);
        slv_resp_o.w_ready  = (w_state_q == W_DATA);
        slv_resp_o.b_valid  = (w_state_q == W_RESP);
        slv_resp_o.b        = b_q;
        slv_resp_o.b.resp   = Resp;
        slv_resp_o.b.user   = '0;
        slv_resp_o.ar_ready = (r_state_q == R_IDLE);
        slv_resp_o.r_valid  = (r_state_q == R_DATA);
        slv_resp_o.r        = r_q;
        slv_resp_o.r.data   = RespData;
        slv_resp_o.r.resp   = Resp;
        slv_resp_o.r.last   = (r_state_q == R_DATA) && (cnt_q == 8'd0);
        slv_resp_o.r.user   = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            b_q       <= '0;
            r_q       <= '0;
            cnt_q     <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            b_q       <= b_d;
            r_q       <= r_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_axi_err_responder.sv
// tb/tb_axi_err_responder.sv - scoreboard bench for axi_err_responder
module tb_axi_err_responder;
    import axi_pkg::*;

    localparam logic [63:0] RESP_DATA = 64'hCA11AB1EBADCAB1E;
    localparam logic [1:0]  EXP_RESP  = 2'b11;

    typedef struct {
        logic [3:0] id;
        logic       last;
    } r_exp_t;

    logic  clk   = 1'b0;
    logic  rst_n = 1'b0;
    req_t  req;
    resp_t rsp;

    int passed = 0;
    int total  = 0;
    int cycle  = 0;
    int b_hs   = 0;
    int r_hs   = 0;

    logic [3:0] exp_b[$];
    r_exp_t     exp_r[$];
    int         r_hs_cycle[$];

    b_chan_t    b_prev;
    r_chan_t    r_prev;
    logic       b_stall = 1'b0;
    logic       r_stall = 1'b0;
    logic [3:0] e_b;
    r_exp_t     e_r;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    axi_err_responder dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .slv_req_i  (req),
        .slv_resp_o (rsp)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(exp_b.size() + exp_r.size()), 64'd0);
    endtask

    // Monitor: pops the scoreboard on every handshake and checks stalled payloads hold.
    always begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
            b_stall = 1'b0;
            r_stall = 1'b0;
        end else begin
            if (rsp.b_valid) begin
                if (b_stall) check("b_stable", 64'(rsp.b == b_prev), 64'd1);
                if (req.b_ready) begin
                    if (exp_b.size() == 0) begin
                        check("b_unexpected", 64'd1, 64'd0);
                    end else begin
                        e_b = exp_b.pop_front();
                        check("b_id", 64'(rsp.b.id), 64'(e_b));
                        check("b_resp", 64'(rsp.b.resp), 64'(EXP_RESP));
                    end
                    b_hs++;
                end
                b_stall = !req.b_ready;
                b_prev  = rsp.b;
            end else begin
                b_stall = 1'b0;
            end
            if (rsp.r_valid) begin
                if (r_stall) check("r_stable", 64'(rsp.r == r_prev), 64'd1);
                if (req.r_ready) begin
                    if (exp_r.size() == 0) begin
                        check("r_unexpected", 64'd1, 64'd0);
                    end else begin
                        e_r = exp_r.pop_front();
                        check("r_id", 64'(rsp.r.id), 64'(e_r.id));
                        check("r_last", 64'(rsp.r.last), 64'(e_r.last));
                        check("r_data", rsp.r.data, RESP_DATA);
                        check("r_resp", 64'(rsp.r.resp), 64'(EXP_RESP));
                    end
                    r_hs++;
                    r_hs_cycle.push_back(cycle);
                end
                r_stall = !req.r_ready;
                r_prev  = rsp.r;
            end else begin
                r_stall = 1'b0;
            end
        end
    end

    initial begin
        int base;
        int n;
        req = '0;
        repeat (3) @(negedge clk);

        check("rst_aw_ready", 64'(rsp.aw_ready), 64'd1);
        check("rst_ar_ready", 64'(rsp.ar_ready), 64'd1);
        check("rst_w_ready",  64'(rsp.w_ready),  64'd0);
        check("rst_b_valid",  64'(rsp.b_valid),  64'd0);
        check("rst_r_valid",  64'(rsp.r_valid),  64'd0);
        check("rst_b_id",     64'(rsp.b.id),     64'd0);
        check("rst_r_id",     64'(rsp.r.id),     64'd0);
        check("rst_r_last",   64'(rsp.r.last),   64'd0);
        check("rst_b_resp",   64'(rsp.b.resp),   64'(EXP_RESP));
        check("rst_r_data",   rsp.r.data,        RESP_DATA);
        rst_n       = 1'b1;
        req.b_ready = 1'b1;
        req.r_ready = 1'b1;

        // Single write
        @(negedge clk);
        check("sw_aw_ready", 64'(rsp.aw_ready), 64'd1);
        req.aw_valid = 1'b1;
        req.aw.id    = 4'd3;
        @(negedge clk);
        req.aw_valid = 1'b0;
        check("sw_w_ready", 64'(rsp.w_ready), 64'd1);
        check("sw_aw_busy", 64'(rsp.aw_ready), 64'd0);
        req.w_valid = 1'b1;
        req.w.last  = 1'b1;
        exp_b.push_back(4'd3);
        @(negedge clk);
        req.w_valid = 1'b0;
        req.w.last  = 1'b0;
        check("sw_b_valid", 64'(rsp.b_valid), 64'd1);
        check("sw_w_ready_off", 64'(rsp.w_ready), 64'd0);
        @(negedge clk);
        check("sw_aw_ready_again", 64'(rsp.aw_ready), 64'd1);
        check("sw_b_done", 64'(rsp.b_valid), 64'd0);

        // Write with W presented before AW
        req.w_valid = 1'b1;
        req.w.last  = 1'b0;
        req.w.data  = {$urandom, $urandom};
        repeat (3) begin
            @(negedge clk);
            check("ew_w_ready_idle", 64'(rsp.w_ready), 64'd0);
        end
        req.aw_valid = 1'b1;
        req.aw.id    = 4'd7;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) req.aw_valid = 1'b0;
            check("ew_w_ready", 64'(rsp.w_ready), 64'd1);
            check("ew_no_early_b", 64'(rsp.b_valid), 64'd0);
            req.w.data = {$urandom, $urandom};
            req.w.last = (i == 3);
            if (i == 3) exp_b.push_back(4'd7);
        end
        @(negedge clk);
        req.w_valid = 1'b0;
        req.w.last  = 1'b0;
        check("ew_b_valid", 64'(rsp.b_valid), 64'd1);
        @(negedge clk);
        check("ew_b_done", 64'(rsp.b_valid), 64'd0);
        check("ew_aw_ready", 64'(rsp.aw_ready), 64'd1);

        // Concurrent AW and AR with both responses back-pressured
        req.b_ready  = 1'b0;
        req.r_ready  = 1'b0;
        req.aw_valid = 1'b1;
        req.aw.id    = 4'd2;
        req.ar_valid = 1'b1;
        req.ar.id    = 4'd9;
        req.ar.len   = 8'd0;
        check("cc_aw_ready", 64'(rsp.aw_ready), 64'd1);
        check("cc_ar_ready", 64'(rsp.ar_ready), 64'd1);
        exp_r.push_back('{4'd9, 1'b1});
        @(negedge clk);
        req.aw.id = 4'd4;
        req.ar.id = 4'd6;
        check("cc_r_valid_first", 64'(rsp.r_valid), 64'd1);
        req.w_valid = 1'b1;
        req.w.last  = 1'b1;
        exp_b.push_back(4'd2);
        @(negedge clk);
        req.w_valid = 1'b0;
        req.w.last  = 1'b0;
        repeat (10) begin
            check("cc_b_valid", 64'(rsp.b_valid), 64'd1);
            check("cc_r_valid", 64'(rsp.r_valid), 64'd1);
            check("cc_aw_blocked", 64'(rsp.aw_ready), 64'd0);
            check("cc_ar_blocked", 64'(rsp.ar_ready), 64'd0);
            @(negedge clk);
        end
        req.aw_valid = 1'b0;
        req.ar_valid = 1'b0;
        req.b_ready  = 1'b1;
        req.r_ready  = 1'b1;
        @(negedge clk);
        check("cc_aw_ready_after", 64'(rsp.aw_ready), 64'd1);
        check("cc_ar_ready_after", 64'(rsp.ar_ready), 64'd1);
        wait_drain("cc_drain");

        // Back-to-back single-beat reads
        base = r_hs_cycle.size();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("b2b_ar_ready", 64'(rsp.ar_ready), 64'd1);
            req.ar_valid = 1'b1;
            req.ar.id    = 4'(i + 1);
            req.ar.len   = 8'd0;
            exp_r.push_back('{4'(i + 1), 1'b1});
            @(negedge clk);
            req.ar_valid = 1'b0;
            check("b2b_r_valid", 64'(rsp.r_valid), 64'd1);
        end
        wait_drain("b2b_drain");
        check("b2b_count", 64'(r_hs_cycle.size() - base), 64'd3);
        if (r_hs_cycle.size() - base == 3) begin
            check("b2b_gap0", 64'(r_hs_cycle[base + 1] - r_hs_cycle[base]), 64'd2);
            check("b2b_gap1", 64'(r_hs_cycle[base + 2] - r_hs_cycle[base + 1]), 64'd2);
        end

        // Max-length read burst with random back-pressure
        @(negedge clk);
        req.ar_valid = 1'b1;
        req.ar.id    = 4'hA;
        req.ar.len   = 8'd255;
        for (int i = 0; i < 256; i++) exp_r.push_back('{4'hA, (i == 255)});
        base = r_hs;
        @(negedge clk);
        req.ar_valid = 1'b0;
        n = 0;
        while (exp_r.size() != 0 && n < 3000) begin
            req.r_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        req.r_ready = 1'b1;
        check("mb_drained", 64'(exp_r.size()), 64'd0);
        check("mb_beats", 64'(r_hs - base), 64'd256);
        @(negedge clk);
        check("mb_r_valid_off", 64'(rsp.r_valid), 64'd0);
        check("mb_ar_ready", 64'(rsp.ar_ready), 64'd1);

        // Asynchronous reset in the middle of a read burst
        req.ar_valid = 1'b1;
        req.ar.id    = 4'd1;
        req.ar.len   = 8'd7;
        for (int i = 0; i < 8; i++) exp_r.push_back('{4'd1, (i == 7)});
        base = r_hs;
        @(negedge clk);
        req.ar_valid = 1'b0;
        n = 0;
        while (r_hs - base < 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rr_beats_before", 64'(r_hs - base), 64'd3);
        rst_n = 1'b0;
        #1;
        check("rr_r_valid_drop", 64'(rsp.r_valid), 64'd0);
        check("rr_ar_ready", 64'(rsp.ar_ready), 64'd1);
        check("rr_aw_ready", 64'(rsp.aw_ready), 64'd1);
        exp_r.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rr_ar_ready_post", 64'(rsp.ar_ready), 64'd1);
        req.ar_valid = 1'b1;
        req.ar.id    = 4'd5;
        req.ar.len   = 8'd0;
        exp_r.push_back('{4'd5, 1'b1});
        base = r_hs;
        @(negedge clk);
        req.ar_valid = 1'b0;
        check("rr_r_valid", 64'(rsp.r_valid), 64'd1);
        check("rr_r_last", 64'(rsp.r.last), 64'd1);
        wait_drain("rr_drain");
        check("rr_beats", 64'(r_hs - base), 64'd1);
        @(negedge clk);
        check("rr_r_idle", 64'(rsp.r_valid), 64'd0);
        check("end_b_queue", 64'(exp_b.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
